// File: rtl/pos_uart_tx.sv
// pos_uart_tx
// Serializes the local player's position into a fixed 6-byte packet and hands
// it byte-by-byte to the UART transmitter. One packet per send_tick. The
// position is snapshotted at packet start; a send_tick that arrives while a
// packet is in flight is remembered (one deep) and starts the next packet
// right after the last byte of the current one.
//
// Packet: HEADER, {6'b0,px[9:8]}, px[7:0], {6'b0,py[9:8]}, py[7:0], xor(b1..b4)
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   host_pos_x  player x position (10 bits used)
//   host_pos_y  player y position (10 bits used)
//   send_tick   one-cycle request to send a packet
//   tx_data     byte presented to the UART
//   tx_valid    tx_data is valid
//   tx_ready    UART accepts the byte this cycle
//   busy        a packet is in progress
//   pkt_cnt     number of fully transmitted packets (wraps)
//   state_dbg   current FSM state (0 = IDLE, 1 = SEND)
//
// Handshake: a byte transfers on a rising edge where tx_valid && tx_ready.
// Once tx_valid is raised it stays high and tx_data stays constant until that
// transfer edge; tx_ready may change freely and has no effect while tx_valid=0.
module pos_uart_tx #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  host_pos_x,
    input  logic [9:0]  host_pos_y,
    input  logic        send_tick,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] pkt_cnt,
    output logic        state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'd5;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        pend_q, pend_d;
    logic [9:0]  px_q, px_d;
    logic [9:0]  py_q, py_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic [15:0] cnt_q, cnt_d;
    logic        xfer;
    logic        restart;

    // Byte i of a packet built from the snapshot registers.
    function automatic logic [7:0] pkt_byte(input logic [2:0] i,
                                            input logic [9:0] x,
                                            input logic [9:0] y);
        logic [7:0] b1, b2, b3, b4;
        b1 = {6'b0, x[9:8]};
        b2 = x[7:0];
        b3 = {6'b0, y[9:8]};
        b4 = y[7:0];
        case (i)
            3'd0:    pkt_byte = HEADER;
            3'd1:    pkt_byte = b1;
            3'd2:    pkt_byte = b2;
            3'd3:    pkt_byte = b3;
            3'd4:    pkt_byte = b4;
            3'd5:    pkt_byte = b1 ^ b2 ^ b3 ^ b4;
            default: pkt_byte = HEADER;
        endcase
    endfunction

    assign xfer = valid_q && tx_ready;
    // A tick landing on the b5 transfer edge counts as pending.
    assign restart = pend_q || send_tick;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        px_d    = px_q;
        py_d    = py_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (send_tick) begin
                    px_d    = host_pos_x;
                    py_d    = host_pos_y;
                    idx_d   = 3'd0;
                    pend_d  = 1'b0;
                    data_d  = HEADER;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Extra ticks while pending is already set merge into it.
                pend_d = pend_q || send_tick;
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        cnt_d = cnt_q + 16'd1;
                        idx_d = 3'd0;
                        if (restart) begin
                            // Next packet starts on the following cycle with
                            // a fresh snapshot; tx_valid stays high.
                            px_d   = host_pos_x;
                            py_d   = host_pos_y;
                            pend_d = 1'b0;
                            data_d = HEADER;
                        end else begin
                            pend_d  = 1'b0;
                            data_d  = 8'h00;
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        data_d = pkt_byte(idx_q + 3'd1, px_q, py_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            pend_q  <= 1'b0;
            px_q    <= 10'd0;
            py_q    <= 10'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            px_q    <= px_d;
            py_q    <= py_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tx_data   = data_q;
    assign tx_valid  = valid_q;
    assign busy      = (state_q == SEND);
    assign pkt_cnt   = cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pos_uart_tx.sv
// Testbench for pos_uart_tx: table of position -> packet vectors, hand-written
// timing sequences (latency, pending, merged ticks, reset abort, counter wrap)
// and a randomized phase, all checked against a packet-level reference model.
module tb_pos_uart_tx;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [9:0]  host_pos_x = '0;
    logic [9:0]  host_pos_y = '0;
    logic        send_tick = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic [15:0] pkt_cnt;
    logic        state_dbg;

    pos_uart_tx #(.HEADER(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .host_pos_x (host_pos_x),
        .host_pos_y (host_pos_y),
        .send_tick  (send_tick),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .pkt_cnt    (pkt_cnt),
        .state_dbg  (state_dbg)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard / model state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];      // bytes the model expects next on the wire
    logic [7:0]  got_q[$];      // bytes actually transferred
    bit          m_active = 0;  // model: a packet is on the wire
    bit          m_pend   = 0;
    logic [15:0] m_cnt    = '0;
    bit          synced   = 0;
    bit          prev_hold = 0;
    logic [7:0]  prev_data = '0;
    bit          preload  = 0;
    int          rdy_mode = 0;  // 0: always ready, 1: random, 2: 1,0,0 pattern
    int          rdy_phase = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference packet built from the position with plain arithmetic.
    task automatic push_pkt(input logic [9:0] x, input logic [9:0] y);
        int hx, lx, hy, ly;
        logic [7:0] c;
        hx = int'(x) / 256;
        lx = int'(x) % 256;
        hy = int'(y) / 256;
        ly = int'(y) % 256;
        c  = 8'(hx) ^ 8'(lx) ^ 8'(hy) ^ 8'(ly);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(hx));
        exp_q.push_back(8'(lx));
        exp_q.push_back(8'(hy));
        exp_q.push_back(8'(ly));
        exp_q.push_back(c);
    endtask

    // Runs at the falling edge: checks outputs against the model state built
    // from earlier edges, then advances the model for the coming rising edge.
    task automatic monitor();
        logic [7:0] e;
        if (synced) begin
            check("busy", 32'(busy), 32'(m_active));
            check("tx_valid", 32'(tx_valid), 32'(m_active));
            check("state_dbg", 32'(state_dbg), 32'(m_active));
            if (!preload) check("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));
            if (prev_hold) begin
                check("hold_valid", 32'(tx_valid), 32'(1'b1));
                check("hold_data", 32'(tx_data), 32'(prev_data));
            end
        end
        if (rst) begin
            exp_q.delete();
            m_active  = 0;
            m_pend    = 0;
            m_cnt     = '0;
            prev_hold = 0;
            synced    = 1;
        end else if (synced) begin
            if (preload) m_cnt = 16'hFFFF;
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
            if (m_active) begin
                if (tx_valid && tx_ready) begin
                    got_q.push_back(tx_data);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        if (errors <= 40) $display("FAIL extra_byte: got %0h expected none", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", 32'(tx_data), 32'(e));
                    end
                    if (exp_q.size() == 0) begin
                        m_cnt = m_cnt + 16'd1;
                        if (m_pend || send_tick) begin
                            push_pkt(host_pos_x, host_pos_y);
                            m_pend = 0;
                        end else begin
                            m_active = 0;
                        end
                    end else if (send_tick) begin
                        m_pend = 1;
                    end
                end else if (send_tick) begin
                    m_pend = 1;
                end
            end else if (send_tick) begin
                push_pkt(host_pos_x, host_pos_y);
                m_active = 1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at the falling edge (monitor) or right after this task returns.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ($urandom_range(0, 3) != 0);
            default: begin
                tx_ready  = (rdy_phase == 0);
                rdy_phase = (rdy_phase + 1) % 3;
            end
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        send_tick = 1'b0;
        step();
        step();
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic tick(input logic [9:0] x, input logic [9:0] y);
        host_pos_x = x;
        host_pos_y = y;
        send_tick  = 1'b1;
        step();
        send_tick  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((m_active || busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL timeout: busy=%0b after %0d cycles, required idle", busy, n);
        end
    endtask

    task automatic check_got(input string name, input logic [47:0] bytes, input int base);
        check({name, "_len"}, 32'(got_q.size() >= base + 6), 32'(1'b1));
        for (int i = 0; i < 6; i++) begin
            if (base + i < got_q.size())
                check(name, 32'(got_q[base + i]), 32'(bytes[8*(5-i) +: 8]));
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [47:0] bytes;   // b0 in the top byte
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{x: 10'h2AB, y: 10'h155, bytes: 48'hA5_02_AB_01_55_FD};
        vecs[1] = '{x: 10'h3FF, y: 10'h000, bytes: 48'hA5_03_FF_00_00_FC};
        vecs[2] = '{x: 10'h000, y: 10'h000, bytes: 48'hA5_00_00_00_00_00};
        vecs[3] = '{x: 10'h100, y: 10'h0FF, bytes: 48'hA5_01_00_00_FF_FE};
        vecs[4] = '{x: 10'h3FF, y: 10'h3FF, bytes: 48'hA5_03_FF_03_FF_00};
        vecs[5] = '{x: 10'h155, y: 10'h2AB, bytes: 48'hA5_01_55_02_AB_FD};

        // Reset state
        do_reset();
        check("rst_tx_valid", 32'(tx_valid), 32'(1'b0));
        check("rst_busy", 32'(busy), 32'(1'b0));
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'h0);

        // Latency and back-to-back timing, tx_ready held high
        rdy_mode = 0;
        tick(10'h2AB, 10'h155);
        for (int i = 0; i < 6; i++) begin
            check("b2b_valid", 32'(tx_valid), 32'(1'b1));
            check("b2b_data", 32'(tx_data), 32'(vecs[0].bytes[8*(5-i) +: 8]));
            step();
        end
        check("b2b_end_valid", 32'(tx_valid), 32'(1'b0));
        check("b2b_end_busy", 32'(busy), 32'(1'b0));
        check("b2b_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // Table vectors, always-ready then 1,0,0 ready pattern
        for (int pass = 0; pass < 2; pass++) begin
            rdy_mode = (pass == 0) ? 0 : 2;
            for (int v = 0; v < 6; v++) begin
                got_q.delete();
                tick(vecs[v].x, vecs[v].y);
                wait_idle(100);
                check("tbl_count", 32'(got_q.size()), 32'd6);
                check_got("tbl_byte", vecs[v].bytes, 0);
            end
        end

        // Position changes right after the tick do not affect the packet
        do_reset();
        rdy_mode = 1;
        tick(10'h2AB, 10'h155);
        host_pos_x = 10'h000;
        host_pos_y = 10'h3FF;
        wait_idle(100);
        check("snap_count", 32'(got_q.size()), 32'd6);
        check_got("snap_byte", vecs[0].bytes, 0);

        // Second tick mid-packet, position changed before the last byte
        do_reset();
        rdy_mode = 0;
        tick(10'h2AB, 10'h155);
        step();
        step();
        send_tick = 1'b1;
        step();
        send_tick = 1'b0;
        host_pos_x = 10'h3FF;
        host_pos_y = 10'h000;
        wait_idle(100);
        check("pend_count", 32'(got_q.size()), 32'd12);
        check_got("pend_pkt1", vecs[0].bytes, 0);
        check_got("pend_pkt2", vecs[1].bytes, 6);
        check("pend_pkt_cnt", 32'(pkt_cnt), 32'd2);

        // Three ticks during one packet give only one extra packet
        do_reset();
        tick(10'h100, 10'h0FF);
        for (int i = 0; i < 3; i++) begin
            send_tick = 1'b1;
            step();
        end
        send_tick = 1'b0;
        wait_idle(100);
        check("merge_count", 32'(got_q.size()), 32'd12);
        check("merge_pkt_cnt", 32'(pkt_cnt), 32'd2);

        // Reset after b2 transferred aborts the packet; tick with rst ignored
        do_reset();
        tick(10'h2AB, 10'h155);
        step();
        step();
        step();
        rst = 1'b1;
        send_tick = 1'b1;
        step();
        rst = 1'b0;
        send_tick = 1'b0;
        check("abort_valid", 32'(tx_valid), 32'(1'b0));
        check("abort_busy", 32'(busy), 32'(1'b0));
        check("abort_pkt_cnt", 32'(pkt_cnt), 32'd0);
        step();
        check("abort_tick_ignored", 32'(busy), 32'(1'b0));
        got_q.delete();
        tick(10'h3FF, 10'h3FF);
        wait_idle(100);
        check("abort_new_count", 32'(got_q.size()), 32'd6);
        check_got("abort_new", vecs[4].bytes, 0);
        check("abort_new_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // Packet counter wraps from FFFF to 0
        do_reset();
        force dut.cnt_q = 16'hFFFF;
        preload = 1;
        step();
        release dut.cnt_q;
        preload = 0;
        step();
        tick(10'h000, 10'h000);
        wait_idle(100);
        check("wrap_pkt_cnt", 32'(pkt_cnt), 32'h0);

        // Randomized ticks, positions and ready against the model
        do_reset();
        rdy_mode = 1;
        for (int c = 0; c < 600; c++) begin
            host_pos_x = 10'($urandom_range(0, 1023));
            host_pos_y = 10'($urandom_range(0, 1023));
            send_tick  = ($urandom_range(0, 9) == 0);
            step();
        end
        send_tick = 1'b0;
        wait_idle(200);
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
